// File: rtl/hyper_pkg.sv
// Shared constants for the hyperbus end-of-transfer tracker.
package hyper_pkg;

  localparam logic HYPER_DIR_READ  = 1'b1;
  localparam logic HYPER_DIR_WRITE = 1'b0;

  localparam int unsigned HYPER_EOT_DEPTH = 4;

endpackage

// File: rtl/udma_hyper_eot_tracker.sv
// Matches hyperbus EOT pulses to the oldest outstanding uDMA launch and
// emits a registered read-done or write-done event for each match.
module udma_hyper_eot_tracker
  import hyper_pkg::*;
#(
  parameter int unsigned DEPTH = HYPER_EOT_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             sys_clk_i,
  input  logic             rstn_i,
  input  logic             rx_launch_i,
  input  logic             tx_launch_i,
  input  logic             eot_i,
  input  logic             clr_i,
  output logic             evt_read_done_o,
  output logic             evt_write_done_o,
  output logic [CNT_W-1:0] pending_cnt_o,
  output logic             full_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wptr, rptr;
  logic [CNT_W-1:0] cnt;
  logic             full_q, ovf_q, unf_q, rd_done_q, wr_done_q;

  logic             pop, unf_evt, rx_ok, tx_ok, ovf_evt;
  logic [CNT_W-1:0] space, cnt_next;
  logic [PW-1:0]    wptr_tx;

  always_comb begin
    pop      = 1'b0;
    unf_evt  = 1'b0;
    rx_ok    = 1'b0;
    tx_ok    = 1'b0;
    ovf_evt  = 1'b0;
    space    = '0;
    cnt_next = cnt;
    wptr_tx  = wptr;
    if (!clr_i) begin
      pop     = eot_i && (cnt != '0);
      unf_evt = eot_i && (cnt == '0);
      // Space is measured after the same-cycle pop; a double push needs two slots.
      space   = DEPTH_C - (cnt - CNT_W'(pop));
      rx_ok   = rx_launch_i && (space != '0);
      tx_ok   = tx_launch_i && (space > CNT_W'(rx_ok));
      ovf_evt = (rx_launch_i && !rx_ok) || (tx_launch_i && !tx_ok);
      cnt_next = cnt - CNT_W'(pop) + CNT_W'(rx_ok) + CNT_W'(tx_ok);
      wptr_tx  = wptr + PW'(rx_ok);
    end
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem       <= '0;
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      rd_done_q <= pop && (mem[rptr] == HYPER_DIR_READ);
      wr_done_q <= pop && (mem[rptr] == HYPER_DIR_WRITE);
      if (clr_i) begin
        wptr   <= '0;
        rptr   <= '0;
        cnt    <= '0;
        full_q <= 1'b0;
        ovf_q  <= 1'b0;
        unf_q  <= 1'b0;
      end else begin
        if (rx_ok) mem[wptr]    <= HYPER_DIR_READ;
        if (tx_ok) mem[wptr_tx] <= HYPER_DIR_WRITE;
        wptr   <= wptr_tx + PW'(tx_ok);
        rptr   <= rptr + PW'(pop);
        cnt    <= cnt_next;
        full_q <= (cnt_next == DEPTH_C);
        if (ovf_evt) ovf_q <= 1'b1;
        if (unf_evt) unf_q <= 1'b1;
      end
    end
  end

  assign evt_read_done_o  = rd_done_q;
  assign evt_write_done_o = wr_done_q;
  assign pending_cnt_o    = cnt;
  assign full_o           = full_q;
  assign overflow_o       = ovf_q;
  assign underflow_o      = unf_q;

endmodule
